// File: rtl/adc_resp_pkg.sv
// Shared types and defaults for the serial ADC responder.
// Holds the frame FSM state encoding and the per-frame sample source selector.
// No logic lives here.
package adc_resp_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int LEAD_BITS_DEF = 4;

  // Sample source selector; the unused code 3 falls back to the external word.
  localparam logic [1:0] MODE_EXT   = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_DATA,
    ST_TAIL
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronises one asynchronous pin into clk and flags its edges.
// Latency: SYNC_STAGES clks to the level, edge pulses are valid in the same clk as the new level.
// No backpressure; every flop resets high so an idle-high line produces no spurious edge.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain followed by one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/adc_serial_responder.sv
// Serial ADC emulator: shifts LEAD_BITS zeros then a DATA_W sample out on sdo, one bit per adclk fall.
// Latency: sdo moves SYNC_STAGES+1 clks after the adclk/cs_n pin edge.
// No backpressure; the reader paces the frame and must hold each adclk phase SYNC_STAGES+2 clks.
module adc_serial_responder
  import adc_resp_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                LEAD_BITS   = LEAD_BITS_DEF,
  parameter logic [DATA_W-1:0] CONST_VAL   = 16'h0A00,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              adclk,
  input  logic              cs_n,
  output logic              sdo,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] ext_sample,
  input  logic [DATA_W-1:0] ramp_step,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [15:0]       frame_cnt,
  output logic [DATA_W-1:0] last_sample
);

  localparam int               CNT_W     = $clog2(LEAD_BITS + DATA_W + 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(LEAD_BITS > 0 ? LEAD_BITS - 1 : 0);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic ad_fall, ad_lvl_unused, ad_rise_unused;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk (clk), .rst (sys_rst), .d (cs_n),
    .lvl (cs_lvl), .rise (cs_rise), .fall (cs_fall)
  );

  // The reader samples on adclk rise, so only the falling edge matters here.
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_adclk_sync (
    .clk (clk), .rst (sys_rst), .d (adclk),
    .lvl (ad_lvl_unused), .rise (ad_rise_unused), .fall (ad_fall)
  );

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d, sample_q, sample_d, src;
  logic [DATA_W-1:0]   ramp_q, ramp_d, last_q, last_d;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                sdo_q, sdo_d, done_q, done_d, abort_q, abort_d;
  logic                armed_q, armed_d;
  logic [SYNC_STAGES:0] settle_q;
  logic                advance;

  // Synchroniser flops reset high, so cs_n is only trusted for arming once the pin has propagated through.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) settle_q <= '0;
    else         settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
  end

  // Frame FSM and output registers.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      sample_q  <= '0;
      ramp_q    <= '0;
      last_q    <= '0;
      mode_q    <= MODE_EXT;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      sdo_q     <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      sample_q  <= sample_d;
      ramp_q    <= ramp_d;
      last_q    <= last_d;
      mode_q    <= mode_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      sdo_q     <= sdo_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      armed_q   <= armed_d;
    end
  end

  // Sample source for the frame about to start; reserved mode behaves as external.
  always_comb begin
    case (mode)
      MODE_RAMP:  src = ramp_q;
      MODE_CONST: src = CONST_VAL;
      default:    src = ext_sample;
    endcase
  end

  // Next-state logic: a cs_n rise always beats a same-clk adclk fall, and adclk is ignored while cs_n is high.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    sample_d  = sample_q;
    ramp_d    = ramp_q;
    last_d    = last_q;
    mode_d    = mode_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    sdo_d     = sdo_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    armed_d   = armed_q | (cs_lvl & settle_q[SYNC_STAGES]);
    advance   = ad_fall & ~cs_lvl;

    case (state_q)
      ST_IDLE: begin
        sdo_d = 1'b0;
        // An adclk fall in the start clk is dropped so the first bit is not skipped.
        if (cs_fall && armed_q) begin
          mode_d    = mode;
          shreg_d   = src;
          sample_d  = src;
          bit_cnt_d = '0;
          if (LEAD_BITS > 0) begin
            state_d = ST_LEAD;
          end else begin
            state_d = ST_DATA;
            sdo_d   = src[DATA_W-1];
          end
        end
      end
      ST_LEAD, ST_DATA: begin
        if (cs_rise) begin
          abort_d = 1'b1;
          sdo_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (advance) begin
          if (state_q == ST_LEAD) begin
            if (bit_cnt_q == LEAD_LAST) begin
              state_d   = ST_DATA;
              bit_cnt_d = '0;
              sdo_d     = shreg_q[DATA_W-1];
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (bit_cnt_q == DATA_LAST) begin
            state_d = ST_TAIL;
            sdo_d   = 1'b0;
          end else begin
            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
            sdo_d     = shreg_d[DATA_W-1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_TAIL: begin
        sdo_d = 1'b0;
        if (cs_rise) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          last_d  = sample_q;
          state_d = ST_IDLE;
          if (mode_q == MODE_RAMP) ramp_d = ramp_q + ramp_step;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sdo         = sdo_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign frame_cnt   = cnt_q;
  assign last_sample = last_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Self-checking bench for adc_serial_responder: a bit-banged reader drives frames from a vector table.
// Expected frame words go into a scoreboard queue at cs_n fall and are compared when the frame closes.
// Hand-written sequences cover mid-frame reset, arming, coincident edges and TAIL behaviour.
module tb_adc_serial_responder;

  localparam int HOLD = 6;

  logic        clk = 1'b0;
  logic        sys_rst, adclk, cs_n, sdo;
  logic [1:0]  mode;
  logic [15:0] ext_sample, ramp_step;
  logic        busy, frame_done, frame_abort;
  logic [15:0] frame_cnt, last_sample;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int abort_seen = 0;
  int both_seen = 0;

  logic [19:0] sb_q[$];

  typedef struct {
    logic [1:0]  m;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] step;
    int          nbits;
    logic [15:0] exp_sample;
    bit          exp_done;
    logic [15:0] exp_cnt;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs[10];

  adc_serial_responder dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .adclk       (adclk),
    .cs_n        (cs_n),
    .sdo         (sdo),
    .mode        (mode),
    .ext_sample  (ext_sample),
    .ramp_step   (ramp_step),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .frame_cnt   (frame_cnt),
    .last_sample (last_sample)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_done) done_seen++;
    if (frame_abort) abort_seen++;
    if (frame_done && frame_abort) both_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One reader frame: cs_n fall, nbits adclk cycles (sample sdo before each rise), optional extra TAIL cycles, cs_n rise.
  task automatic run_frame(input logic [1:0] m, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] step, input int nbits, input bit coinc,
                           input int extra, input logic [15:0] exp_sample);
    logic [19:0] cap;
    logic [19:0] expw;
    logic [19:0] full;
    mode       = m;
    ext_sample = e0;
    ramp_step  = step;
    if (coinc) begin
      adclk = 1'b1;
      wait_clks(HOLD);
      cs_n  = 1'b0;
      adclk = 1'b0;
    end else begin
      adclk = 1'b0;
      cs_n  = 1'b0;
    end
    full = {4'h0, exp_sample};
    sb_q.push_back(full >> (20 - nbits));
    wait_clks(HOLD);
    ext_sample = e1;
    check("busy_in_frame", busy, 1);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      cap   = {cap[18:0], sdo};
      adclk = 1'b1;
      wait_clks(HOLD);
      adclk = 1'b0;
      wait_clks(HOLD);
    end
    for (int i = 0; i < extra; i++) begin
      adclk = 1'b1;
      wait_clks(HOLD);
      check("tail_sdo_hi", sdo, 0);
      adclk = 1'b0;
      wait_clks(HOLD);
      check("tail_sdo_lo", sdo, 0);
    end
    cs_n = 1'b1;
    wait_clks(HOLD);
    expw = sb_q.pop_front();
    check("frame_bits", cap, expw);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sdo"}, sdo, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_abort"}, frame_abort, 0);
    check({tag, "_cnt"}, frame_cnt, 0);
    check({tag, "_last"}, last_sample, 0);
  endtask

  initial begin
    int d0, a0, bad_sdo, bad_busy;

    vecs[0] = '{2'd2, 16'hFFFF, 16'hFFFF, 16'h0000, 20, 16'h0A00, 1'b1, 16'd1, 16'h0A00};
    vecs[1] = '{2'd0, 16'h0860, 16'h0C0D, 16'h0000, 20, 16'h0860, 1'b1, 16'd2, 16'h0860};
    vecs[2] = '{2'd0, 16'h0C0D, 16'h0C0D, 16'h0000, 20, 16'h0C0D, 1'b1, 16'd3, 16'h0C0D};
    vecs[3] = '{2'd1, 16'h0000, 16'h0000, 16'h8000, 20, 16'h0000, 1'b1, 16'd4, 16'h0000};
    vecs[4] = '{2'd1, 16'h0000, 16'h0000, 16'h8000, 20, 16'h8000, 1'b1, 16'd5, 16'h8000};
    vecs[5] = '{2'd1, 16'h0000, 16'h0000, 16'h8000, 20, 16'h0000, 1'b1, 16'd6, 16'h0000};
    vecs[6] = '{2'd1, 16'h0000, 16'h0000, 16'h8000, 10, 16'h8000, 1'b0, 16'd6, 16'h0000};
    vecs[7] = '{2'd1, 16'h0000, 16'h0000, 16'h8000, 20, 16'h8000, 1'b1, 16'd7, 16'h8000};
    vecs[8] = '{2'd1, 16'h0000, 16'h0000, 16'h0100, 20, 16'h0000, 1'b1, 16'd8, 16'h0000};
    vecs[9] = '{2'd3, 16'h1234, 16'h1234, 16'h0000, 20, 16'h1234, 1'b1, 16'd9, 16'h1234};

    sys_rst    = 1'b1;
    adclk      = 1'b0;
    cs_n       = 1'b1;
    mode       = 2'd0;
    ext_sample = 16'h0000;
    ramp_step  = 16'h0000;
    wait_clks(3);
    check_outputs_zero("reset");
    sys_rst = 1'b0;
    wait_clks(10);

    // Table-driven frames.
    for (int v = 0; v < 10; v++) begin
      d0 = done_seen;
      a0 = abort_seen;
      run_frame(vecs[v].m, vecs[v].e0, vecs[v].e1, vecs[v].step, vecs[v].nbits, 1'b0, 0,
                vecs[v].exp_sample);
      check("done_pulses", done_seen - d0, vecs[v].exp_done ? 1 : 0);
      check("abort_pulses", abort_seen - a0, vecs[v].exp_done ? 0 : 1);
      check("frame_cnt", frame_cnt, vecs[v].exp_cnt);
      check("last_sample", last_sample, vecs[v].exp_last);
      check("busy_after", busy, 0);
      check("sdo_after", sdo, 0);
    end

    // Reset in the middle of a frame with cs_n held low, then an adclk burst that must not start a frame.
    mode  = 2'd2;
    cs_n  = 1'b0;
    wait_clks(HOLD);
    for (int i = 0; i < 8; i++) begin
      adclk = 1'b1;
      wait_clks(HOLD);
      adclk = 1'b0;
      wait_clks(HOLD);
    end
    check("busy_before_rst", busy, 1);
    d0 = done_seen;
    a0 = abort_seen;
    sys_rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    wait_clks(2);
    sys_rst = 1'b0;
    wait_clks(HOLD);
    bad_sdo  = 0;
    bad_busy = 0;
    for (int i = 0; i < 20; i++) begin
      adclk = 1'b1;
      wait_clks(HOLD);
      if (sdo !== 1'b0) bad_sdo++;
      if (busy !== 1'b0) bad_busy++;
      adclk = 1'b0;
      wait_clks(HOLD);
      if (sdo !== 1'b0) bad_sdo++;
      if (busy !== 1'b0) bad_busy++;
    end
    check("unarmed_sdo_count", bad_sdo, 0);
    check("unarmed_busy_count", bad_busy, 0);
    check("rst_no_done", done_seen - d0, 0);
    check("rst_no_abort", abort_seen - a0, 0);
    check("unarmed_cnt", frame_cnt, 0);
    cs_n = 1'b1;
    wait_clks(HOLD);

    // Re-armed by cs_n high: a normal CONST frame, then RAMP shows the ramp register was cleared.
    run_frame(2'd2, 16'h0000, 16'h0000, 16'h0000, 20, 1'b0, 0, 16'h0A00);
    check("rearm_cnt", frame_cnt, 1);
    check("rearm_last", last_sample, 16'h0A00);
    run_frame(2'd1, 16'h0000, 16'h0000, 16'h0001, 20, 1'b0, 0, 16'h0000);
    check("ramp_cleared_cnt", frame_cnt, 2);

    // cs_n fall coincident with an adclk fall, plus extra adclk cycles while in TAIL.
    d0 = done_seen;
    run_frame(2'd0, 16'hA5C3, 16'h0000, 16'h0000, 20, 1'b1, 5, 16'hA5C3);
    check("coinc_done", done_seen - d0, 1);
    check("coinc_cnt", frame_cnt, 3);
    check("coinc_last", last_sample, 16'hA5C3);

    check("done_abort_overlap", both_seen, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
